led_sequencer: RTL and testbench
================================

# led_sequencer

Programmable LED effect sequencer that owns the 32-bit `counter` block and drives the LED outputs. It holds a small table of steps, each with an LED pattern and a dwell duration. It loads each duration into the counter, enables counting and advances on `limit_reached`. It sits between the top-level mode/config logic and the LED pins, and is the only master of the counter's control inputs.

## Interface
- `LED_W`, 8, LED output width
- `STEPS`, 8, step table depth (power of two)
- `STEP_AW`, 3, log2(STEPS)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low; clears all state
- `cfg_we`  in  1  write step table entry
- `cfg_addr`  in  STEP_AW  step index to write
- `cfg_pattern`  in  LED_W  LED pattern for that step
- `cfg_duration`  in  32  counter limit for that step
- `num_steps`  in  STEP_AW+1  active step count, valid 1..STEPS
- `start`  in  1  begin sequence at step 0 (pulse)
- `stop`  in  1  abort sequence (pulse)
- `loop_en`  in  1  1 = repeat at end of sequence, 0 = run once
- `cnt_limit`  out  32  to counter `limit`
- `cnt_limit_we`  out  1  to counter `limit_we`
- `cnt_reset`  out  1  to counter `reset` (active-high)
- `cnt_enable`  out  1  to counter `enable`
- `cnt_limit_reached`  in  1  from counter `limit_reached`
- `leds`  out  LED_W  LED drive
- `busy`  out  1  sequence running
- `done`  out  1  one-cycle pulse at end of a non-looping sequence

## Operation
- Counter contract: count cleared while `cnt_reset`=1; +1 per cycle while `cnt_enable`=1; `limit_reached` is combinational (count == limit).
- Step table is a register array (pattern + duration). `cfg_we` writes it in any state; a write takes effect the next time that step enters LOAD.
- FSM states: IDLE, LOAD, RUN, ADVANCE.
  - IDLE: `cnt_reset`=1, `cnt_enable`=0, `busy`=0. `start` with 1 ≤ `num_steps` ≤ STEPS sets idx=0 and moves to LOAD. Otherwise `start` is ignored.
  - LOAD: `cnt_limit`=duration[idx], `cnt_limit_we`=1, `cnt_reset`=1, `cnt_enable`=0. Next state is RUN. `leds`<=pattern[idx] at the LOAD→RUN edge.
  - RUN: `cnt_enable`=1. On `cnt_limit_reached`=1, go to ADVANCE.
  - ADVANCE: `cnt_enable`=0. If idx < `num_steps`-1, idx+1 and go to LOAD. Else, if `loop_en`, idx=0 and go to LOAD. Else assert `done` for one cycle, go to IDLE, and `leds` hold their last pattern.
- `stop` in any non-IDLE state goes to IDLE next edge and `leds`<=0. If `stop` and `start` arrive together, `stop` wins.
- `start` while `busy` is ignored.
- `num_steps` is sampled continuously. If it is lowered below idx+1 mid-run, the end condition is taken at the next ADVANCE.
- `cnt_limit` holds its last value outside LOAD.

## Timing
- Reset values: `leds`=0, `busy`=0, `done`=0, `cnt_limit`=0, `cnt_limit_we`=0, `cnt_reset`=1, `cnt_enable`=0, idx=0, state=IDLE, table=0.
- Counter control outputs are Moore decodes of the registered state. `leds` is a register.
- `start` is sampled at edge T. LOAD occupies cycle T+1 and `leds` update at edge T+2.
- Step period = LOAD(1) + RUN(duration+1) + ADVANCE(1) = duration+3 cycles.
- Duration 0 gives RUN of 1 cycle and a 3-cycle period.
- `busy`=1 in LOAD, RUN and ADVANCE.
- `done` is asserted in the cycle after the final ADVANCE (registered).

## Configuration
- `LED_SEQ_PINGPONG_EN`
  - Defined: when `loop_en`=1, the sequence reverses direction at each end instead of wrapping (0..N-1, N-2..0, 1..). Endpoints are not repeated. With `num_steps`=1, idx stays 0.
  - Undefined: idx wraps N-1→0 and the direction register is not built.

## Structure
- A shared `led_seq_pkg` holds the state enum (IDLE/LOAD/RUN/ADVANCE), the duration width constant (32) and the step-entry struct (pattern, duration).
- One sub-module, `led_seq_table`: the step register file with a write port and an async read port.

## Test plan
- Reset low 2 cycles, then high → all outputs at reset values; `start` with `num_steps`=0 leaves `busy`=0.
- 3 steps with patterns 0x01/0x02/0x04, durations 2/0/5, `loop_en`=0, `start` → `leds` sequence 01,02,04 with periods 5, 3, 8 cycles; one `done` pulse; `leds` hold 0x04.
- Same table with `loop_en`=1 → after step 2, `leds` return to 0x01. With `LED_SEQ_PINGPONG_EN`, order is 01,02,04,02,01,02.
- `stop` asserted in mid-RUN → IDLE next edge, `leds`=0, `cnt_enable`=0, `cnt_reset`=1; `start` and `stop` together → stays IDLE.
- `cfg_we` rewrites step 1 to 0xAA/duration 1 while step 0 is running → step 1 shows 0xAA for a 4-cycle period.
- Counter limit check: during each LOAD, `cnt_limit_we`=1 and `cnt_limit` equals that step's duration; a second `start` while `busy` changes nothing.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED effect sequencer.
// Holds the FSM state enum, the counter duration width and the step-table entry.
package led_seq_pkg;

  localparam int DUR_W   = 32;
  localparam int LED_W_C = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  typedef struct packed {
    logic [LED_W_C-1:0] pattern;
    logic [DUR_W-1:0]   duration;
  } step_t;

endpackage

// File: rtl/led_seq_table.sv
// Step register file: one synchronous write port, one asynchronous read port.
// Entries clear to zero on reset.
module led_seq_table
  import led_seq_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int STEP_AW = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_we,
  input  logic [STEP_AW-1:0] i_waddr,
  input  step_t              i_wdata,
  input  logic [STEP_AW-1:0] i_raddr,
  output step_t              o_rdata
);

  step_t r_mem [STEPS];

  // Table storage: cleared by reset, written whenever the write strobe is high.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/led_sequencer.sv
// LED effect sequencer: steps through a table of {pattern, duration} entries,
// programming and enabling the external 32-bit counter for each dwell.
// Optional build macro LED_SEQ_PINGPONG_EN: looping sequences bounce between
// the ends of the table instead of wrapping back to step 0.
//
// Counter handshake: in LOAD the limit is written (cnt_limit_we=1) while the
// count is held cleared; in RUN the counter is enabled and the sequencer
// leaves RUN on the first cycle cnt_limit_reached is seen high.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W   = LED_W_C,
  parameter int STEPS   = 8,
  parameter int STEP_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [STEP_AW-1:0] cfg_addr,
  input  logic [LED_W-1:0]   cfg_pattern,
  input  logic [DUR_W-1:0]   cfg_duration,
  input  logic [STEP_AW:0]   num_steps,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [DUR_W-1:0]   cnt_limit,
  output logic               cnt_limit_we,
  output logic               cnt_reset,
  output logic               cnt_enable,
  input  logic               cnt_limit_reached,
  output logic [LED_W-1:0]   leds,
  output logic               busy,
  output logic               done,
  output state_t             o_state
);

  localparam logic [STEP_AW:0]   STEPS_L = (STEP_AW+1)'(STEPS);
  localparam logic [STEP_AW:0]   ONE_N   = (STEP_AW+1)'(1);
  localparam logic [STEP_AW-1:0] ONE_I   = STEP_AW'(1);

  state_t             r_state;
  logic [STEP_AW-1:0] r_idx;
  logic [LED_W-1:0]   r_leds;
  logic               r_done;
  logic [DUR_W-1:0]   r_limit_hold;
`ifdef LED_SEQ_PINGPONG_EN
  logic               r_dir_down;
  logic               w_multi;
`endif

  step_t              w_wdata;
  step_t              w_step;
  logic               w_num_ok;
  logic               w_has_next;

  assign w_wdata = '{pattern: cfg_pattern, duration: cfg_duration};

  led_seq_table #(
    .STEPS   (STEPS),
    .STEP_AW (STEP_AW)
  ) u_table (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_we      (cfg_we),
    .i_waddr   (cfg_addr),
    .i_wdata   (w_wdata),
    .i_raddr   (r_idx),
    .o_rdata   (w_step)
  );

  // A start is honoured only for a step count inside 1..STEPS.
  assign w_num_ok   = (num_steps != '0) && (num_steps <= STEPS_L);
  // num_steps is live, so the end test uses whatever value is present now.
  assign w_has_next = (({1'b0, r_idx} + ONE_N) < num_steps);
`ifdef LED_SEQ_PINGPONG_EN
  assign w_multi    = (num_steps > ONE_N);
`endif

  // Sequencer FSM with registered LED, done and held-limit outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_leds       <= '0;
      r_done       <= 1'b0;
      r_limit_hold <= '0;
`ifdef LED_SEQ_PINGPONG_EN
      r_dir_down   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && stop) begin
        // Abort blanks the LEDs; stop also beats a simultaneous start.
        r_state <= ST_IDLE;
        r_leds  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop && w_num_ok) begin
              r_idx   <= '0;
              r_state <= ST_LOAD;
`ifdef LED_SEQ_PINGPONG_EN
              r_dir_down <= 1'b0;
`endif
            end
          end
          ST_LOAD: begin
            r_limit_hold <= w_step.duration;
            r_leds       <= w_step.pattern;
            r_state      <= ST_RUN;
          end
          ST_RUN: begin
            if (cnt_limit_reached) begin
              r_state <= ST_ADVANCE;
            end
          end
          ST_ADVANCE: begin
`ifdef LED_SEQ_PINGPONG_EN
            if (r_dir_down && loop_en) begin
              // Walking back down; bounce at step 0 without repeating it.
              if (r_idx != '0) begin
                r_idx <= r_idx - ONE_I;
              end else begin
                r_dir_down <= 1'b0;
                r_idx      <= w_multi ? ONE_I : '0;
              end
              r_state <= ST_LOAD;
            end else if (w_has_next) begin
              r_dir_down <= 1'b0;
              r_idx      <= r_idx + ONE_I;
              r_state    <= ST_LOAD;
            end else if (loop_en) begin
              // Top end reached; turn around unless the table has one step.
              if (w_multi) begin
                r_dir_down <= 1'b1;
                r_idx      <= r_idx - ONE_I;
              end else begin
                r_idx <= '0;
              end
              r_state <= ST_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
`else
            if (w_has_next) begin
              r_idx   <= r_idx + ONE_I;
              r_state <= ST_LOAD;
            end else if (loop_en) begin
              r_idx   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
`endif
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Counter controls decode straight from the registered state.
  assign cnt_limit_we = (r_state == ST_LOAD);
  assign cnt_reset    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign cnt_enable   = (r_state == ST_RUN);
  assign busy         = (r_state != ST_IDLE);
  // Live table value while loading, otherwise the last loaded limit.
  assign cnt_limit    = (r_state == ST_LOAD) ? w_step.duration : r_limit_hold;
  assign leds         = r_leds;
  assign done         = r_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a behavioural model of the counter.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_pattern = '0;
  logic [31:0] cfg_duration = '0;
  logic [3:0]  num_steps = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] cnt_limit;
  logic        cnt_limit_we;
  logic        cnt_reset;
  logic        cnt_enable;
  logic        cnt_limit_reached;
  logic [7:0]  leds;
  logic        busy;
  logic        done;
  led_seq_pkg::state_t st;

  led_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_pattern       (cfg_pattern),
    .cfg_duration      (cfg_duration),
    .num_steps         (num_steps),
    .start             (start),
    .stop              (stop),
    .loop_en           (loop_en),
    .cnt_limit         (cnt_limit),
    .cnt_limit_we      (cnt_limit_we),
    .cnt_reset         (cnt_reset),
    .cnt_enable        (cnt_enable),
    .cnt_limit_reached (cnt_limit_reached),
    .leds              (leds),
    .busy              (busy),
    .done              (done),
    .o_state           (st)
  );

  // Clock
  always #5 clk = ~clk;

  // Counter model: clear while reset, count while enable, limit register.
  logic [31:0] m_count = '0;
  logic [31:0] m_limit = '0;
  always @(posedge clk) begin
    if (cnt_reset) m_count <= '0;
    else if (cnt_enable) m_count <= m_count + 32'd1;
    if (cnt_limit_we) m_limit <= cnt_limit;
  end
  assign cnt_limit_reached = (m_count == m_limit);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs set at negedge, outputs sampled at the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] p, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_duration = d;
    tick();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  leds;
    logic        busy;
    logic        done;
    logic        en;
    logic        crst;
    logic        we;
    logic [31:0] lim;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [7:0] l, input logic b, input logic d,
                              input logic e, input logic r, input logic w, input logic [31:0] lim);
    vec_t v;
    v.start = s; v.leds = l; v.busy = b; v.done = d;
    v.en = e; v.crst = r; v.we = w; v.lim = lim;
    return v;
  endfunction

  vec_t       vecs[18];
  logic [7:0] exp_seq[6];
  logic [7:0] got_seq[6];

  initial begin
    int   got;
    int   n;
    logic [7:0]  prev;
    logic [31:0] lim_cap;
    logic        seen_done;

    // Run-once trace: steps 01/d2, 02/d0, 04/d5 -> periods 5, 3, 8.
    vecs[0]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2); // LOAD s0
    vecs[1]  = mk(1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2); // RUN
    vecs[2]  = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2); // start while busy
    vecs[3]  = mk(1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
    vecs[4]  = mk(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2); // ADVANCE
    vecs[5]  = mk(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0); // LOAD s1
    vecs[6]  = mk(1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); // RUN (1 cycle)
    vecs[7]  = mk(1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0); // ADVANCE
    vecs[8]  = mk(1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5); // LOAD s2
    for (int i = 9; i < 15; i++)
      vecs[i] = mk(1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5); // RUN x6
    vecs[15] = mk(1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5); // ADVANCE
    vecs[16] = mk(1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5); // IDLE, done
    vecs[17] = mk(1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);

`ifdef LED_SEQ_PINGPONG_EN
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
    exp_seq[3] = 8'h02; exp_seq[4] = 8'h01; exp_seq[5] = 8'h02;
`else
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
    exp_seq[3] = 8'h01; exp_seq[4] = 8'h02; exp_seq[5] = 8'h04;
`endif

    // Reset: low for two cycles, then release.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_leds", leds, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_limit", cnt_limit, 32'd0);
    check("rst_limit_we", cnt_limit_we, 1'b0);
    check("rst_cnt_reset", cnt_reset, 1'b1);
    check("rst_cnt_enable", cnt_enable, 1'b0);

    // Out-of-range step counts ignore start.
    num_steps = 4'd0; start = 1'b1; tick(); start = 1'b0;
    check("start_n0_busy", busy, 1'b0);
    num_steps = 4'd9; start = 1'b1; tick(); start = 1'b0;
    check("start_n9_busy", busy, 1'b0);
    check("start_n9_we", cnt_limit_we, 1'b0);

    cfg_write(3'd0, 8'h01, 32'd2);
    cfg_write(3'd1, 8'h02, 32'd0);
    cfg_write(3'd2, 8'h04, 32'd5);

    // Table-driven run-once trace.
    num_steps = 4'd3; loop_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start;
      tick();
      start = 1'b0;
      check($sformatf("v%0d_leds", i), leds, vecs[i].leds);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d_done", i), done, vecs[i].done);
      check($sformatf("v%0d_en", i), cnt_enable, vecs[i].en);
      check($sformatf("v%0d_crst", i), cnt_reset, vecs[i].crst);
      check($sformatf("v%0d_we", i), cnt_limit_we, vecs[i].we);
      check($sformatf("v%0d_lim", i), cnt_limit, vecs[i].lim);
    end

    // Looping: record the first six LED patterns.
    loop_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
    prev = leds; got = 0; seen_done = 1'b0; n = 0;
    while (got < 6 && n < 300) begin
      tick(); n++;
      if (done) seen_done = 1'b1;
      if (leds !== prev) begin
        got_seq[got] = leds;
        got++;
      end
      prev = leds;
    end
    check("loop_seq_count", got, 6);
    for (int i = 0; i < got; i++) check($sformatf("loop_seq%0d", i), got_seq[i], exp_seq[i]);
    check("loop_no_done", seen_done, 1'b0);

    // Stop in mid-RUN.
    n = 0;
    while (!cnt_enable && n < 50) begin tick(); n++; end
    check("stop_found_run", cnt_enable, 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", busy, 1'b0);
    check("stop_leds", leds, 8'h00);
    check("stop_en", cnt_enable, 1'b0);
    check("stop_crst", cnt_reset, 1'b1);

    // Start and stop together: stays idle.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 1'b0);
    tick();
    check("startstop_busy2", busy, 1'b0);
    check("startstop_we", cnt_limit_we, 1'b0);

    // Rewrite step 1 while step 0 runs.
    loop_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (leds !== 8'h01 && n < 20) begin tick(); n++; end
    check("cfg_s0_leds", leds, 8'h01);
    cfg_write(3'd1, 8'hAA, 32'd1);
    n = 0; lim_cap = 32'hFFFF_FFFF;
    while (leds !== 8'hAA && n < 40) begin
      if (cnt_limit_we) lim_cap = cnt_limit;
      tick(); n++;
    end
    check("cfg_s1_leds", leds, 8'hAA);
    check("cfg_s1_limit", lim_cap, 32'd1);
    n = 0;
    while (leds === 8'hAA && n < 40) begin tick(); n++; end
    check("cfg_s1_period", n, 4);
    check("cfg_s2_leds", leds, 8'h04);
    n = 0; seen_done = 1'b0;
    while (!seen_done && n < 40) begin
      tick(); n++;
      if (done) seen_done = 1'b1;
    end
    check("cfg_done_seen", seen_done, 1'b1);
    tick();
    check("cfg_done_pulse", done, 1'b0);
    check("cfg_leds_hold", leds, 8'h04);
    check("cfg_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
